// File: rtl/ascon_pkg.sv
// Shared constants and state encoding for the Ascon-128 decryption controller.
package ascon_pkg;

    // Ascon-128 defaults: initial value and round counts.
    localparam logic [63:0] AsconIv = 64'h80400c0600000000;
    localparam int unsigned AsconRa = 12;
    localparam int unsigned AsconRb = 6;

    // State word layout: x0 is the rate lane at the top of S.
    localparam int unsigned LaneW  = 64;
    localparam int unsigned StateW = 320;
    localparam int unsigned X0Lsb  = 256;
    localparam int unsigned X1Lsb  = 192;
    localparam int unsigned X2Lsb  = 128;
    localparam int unsigned X3Lsb  = 64;
    localparam int unsigned X4Lsb  = 0;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StWaitCt,
        StPermCt,
        StFinal,
        StCheck
    } state_e;

    // States during which the external permutation core is being sequenced.
    function automatic logic is_perm_state(state_e st);
        return (st == StInit) || (st == StPermCt) || (st == StFinal);
    endfunction

endpackage

// File: rtl/ascon_pad_mask.sv
// Byte mask and 10* pad for a partial final block of n bytes (first byte in [63:56]).
module ascon_pad_mask (
    input  logic [2:0]  n_i,
    output logic [63:0] mask_o,
    output logic [63:0] pad_o
);

    logic [5:0] shamt;

    // Shift by whole bytes: mask covers the top n bytes, pad marks byte n.
    always_comb begin
        shamt  = {n_i, 3'b000};
        mask_o = ~(64'hFFFF_FFFF_FFFF_FFFF >> shamt);
        pad_o  = {8'h80, 56'h0} >> shamt;
    end

endmodule

// File: rtl/ascon_dec_ctrl.sv
// Ascon-128 decryption controller: owns the 320-bit state, sequences an external
// round-serial permutation core, absorbs ciphertext and checks the tag.
module ascon_dec_ctrl
    import ascon_pkg::*;
#(
    parameter logic [63:0] IV = AsconIv,
    parameter int unsigned RA = AsconRa,
    parameter int unsigned RB = AsconRb
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] nonce,
    input  logic [127:0] tag_in,
    output logic         busy,
    input  logic         ct_valid,
    output logic         ct_ready,
    input  logic [63:0]  ct_data,
    input  logic         ct_last,
    input  logic [2:0]   ct_bytes,
    output logic         pt_valid,
    output logic [63:0]  pt_data,
    output logic [3:0]   pt_bytes,
    output logic         done,
    output logic         tag_ok,
    output logic         perm_sel1,
    output logic         perm_sel2,
    output logic         perm_sel_cst,
    output logic         perm_done,
    output logic [319:0] perm_in,
    input  logic [319:0] perm_out
);

    localparam logic [3:0] RaCnt = 4'(RA);
    localparam logic [3:0] RbCnt = 4'(RB);

    state_e              state_q, state_d;
    logic [StateW-1:0]   s_q, s_d;
    logic [127:0]        key_q, key_d;
    logic [127:0]        tag_q, tag_d;
    logic [1:0]          phase_q, phase_d;
    logic [3:0]          round_q, round_d;
    logic                pt_valid_q, pt_valid_d;
    logic [63:0]         pt_data_q, pt_data_d;
    logic [3:0]          pt_bytes_q, pt_bytes_d;
    logic                done_q, done_d;
    logic                tag_ok_q, tag_ok_d;

    logic                in_perm;
    logic [3:0]          round_tgt;
    logic                perm_last;
    logic                handshake;
    logic [63:0]         x0;
    logic [63:0]         last_mask;
    logic [63:0]         last_pad;
    logic [127:0]        tag_calc;

    ascon_pad_mask u_pad_mask (
        .n_i    (ct_bytes),
        .mask_o (last_mask),
        .pad_o  (last_pad)
    );

    assign x0        = s_q[X0Lsb +: LaneW];
    assign tag_calc  = {s_q[X3Lsb +: LaneW], s_q[X4Lsb +: LaneW]} ^ key_q;
    assign handshake = (state_q == StWaitCt) && ct_valid;

    // Permutation sequencing: which round count applies and when it is finished.
    always_comb begin
        in_perm   = is_perm_state(state_q);
        round_tgt = (state_q == StPermCt) ? RbCnt : RaCnt;
        perm_last = in_perm && (round_q == round_tgt);
    end

    // Core control strobes: P0 selects the state, P1 injects the round constant.
    always_comb begin
        perm_sel1    = 1'b0;
        perm_sel2    = 1'b0;
        perm_sel_cst = 1'b0;
        perm_done    = 1'b0;
        perm_in      = s_q;
        if (in_perm) begin
            if (perm_last) begin
                perm_done = 1'b1;
                perm_sel2 = 1'b1;
            end else begin
                perm_sel2    = (phase_q == 2'd0);
                perm_sel1    = (phase_q == 2'd0) && (round_q == 4'd0);
                perm_sel_cst = (phase_q == 2'd1);
            end
        end
    end

    // Phase/round counters advance only mid-permutation and sit at zero otherwise,
    // so every permutation starts from a clean count.
    always_comb begin
        phase_d = 2'd0;
        round_d = 4'd0;
        if (in_perm && !perm_last) begin
            phase_d = phase_q + 2'd1;
            round_d = (phase_q == 2'd3) ? round_q + 4'd1 : round_q;
        end
    end

    // Main next-state and datapath.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        key_d      = key_q;
        tag_d      = tag_q;
        pt_valid_d = 1'b0;
        pt_data_d  = pt_data_q;
        pt_bytes_d = pt_bytes_q;
        done_d     = 1'b0;
        tag_ok_d   = tag_ok_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    key_d    = key;
                    tag_d    = tag_in;
                    s_d      = {IV, key, nonce};
                    tag_ok_d = 1'b0;
                    state_d  = StInit;
                end
            end

            StInit: begin
                if (perm_last) begin
                    // Key into x3||x4, then empty-AD domain separation on the LSB.
                    s_d     = perm_out ^ {192'h0, key_q ^ 128'h1};
                    state_d = StWaitCt;
                end
            end

            StWaitCt: begin
                if (handshake) begin
                    pt_valid_d = 1'b1;
                    if (ct_last) begin
                        pt_data_d  = (ct_data ^ x0) & last_mask;
                        pt_bytes_d = {1'b0, ct_bytes};
                        s_d[X0Lsb +: LaneW] = ((ct_data & last_mask) | (x0 & ~last_mask))
                                              ^ last_pad;
                        s_d[X1Lsb +: LaneW] = s_q[X1Lsb +: LaneW] ^ key_q[127:64];
                        s_d[X2Lsb +: LaneW] = s_q[X2Lsb +: LaneW] ^ key_q[63:0];
                        state_d    = StFinal;
                    end else begin
                        pt_data_d  = ct_data ^ x0;
                        pt_bytes_d = 4'd8;
                        s_d[X0Lsb +: LaneW] = ct_data;
                        state_d    = StPermCt;
                    end
                end
            end

            StPermCt: begin
                if (perm_last) begin
                    s_d     = perm_out;
                    state_d = StWaitCt;
                end
            end

            StFinal: begin
                if (perm_last) begin
                    s_d     = perm_out;
                    state_d = StCheck;
                end
            end

            StCheck: begin
                done_d   = 1'b1;
                tag_ok_d = (tag_calc == tag_q);
                state_d  = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register; reset also drops any pending pt/done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            s_q        <= '0;
            key_q      <= '0;
            tag_q      <= '0;
            phase_q    <= '0;
            round_q    <= '0;
            pt_valid_q <= 1'b0;
            pt_data_q  <= '0;
            pt_bytes_q <= '0;
            done_q     <= 1'b0;
            tag_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            key_q      <= key_d;
            tag_q      <= tag_d;
            phase_q    <= phase_d;
            round_q    <= round_d;
            pt_valid_q <= pt_valid_d;
            pt_data_q  <= pt_data_d;
            pt_bytes_q <= pt_bytes_d;
            done_q     <= done_d;
            tag_ok_q   <= tag_ok_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign ct_ready = (state_q == StWaitCt);
    assign pt_valid = pt_valid_q;
    assign pt_data  = pt_data_q;
    assign pt_bytes = pt_bytes_q;
    assign done     = done_q;
    assign tag_ok   = tag_ok_q;

endmodule

// File: tb/tb_ascon_dec_ctrl.sv
// Self-checking bench for ascon_dec_ctrl with a behavioural permutation core and
// a block-level Ascon-128 decryption reference model.
module tb_ascon_dec_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0, nonce = '0, tag_in = '0;
    logic         busy;
    logic         ct_valid = 1'b0;
    logic         ct_ready;
    logic [63:0]  ct_data = '0;
    logic         ct_last = 1'b0;
    logic [2:0]   ct_bytes = '0;
    logic         pt_valid;
    logic [63:0]  pt_data;
    logic [3:0]   pt_bytes;
    logic         done, tag_ok;
    logic         perm_sel1, perm_sel2, perm_sel_cst, perm_done;
    logic [319:0] perm_in, perm_out;

    always #5 clk = ~clk;

    ascon_dec_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .nonce(nonce),
        .tag_in(tag_in), .busy(busy), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .ct_data(ct_data), .ct_last(ct_last), .ct_bytes(ct_bytes),
        .pt_valid(pt_valid), .pt_data(pt_data), .pt_bytes(pt_bytes),
        .done(done), .tag_ok(tag_ok), .perm_sel1(perm_sel1), .perm_sel2(perm_sel2),
        .perm_sel_cst(perm_sel_cst), .perm_done(perm_done), .perm_in(perm_in),
        .perm_out(perm_out)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- Ascon permutation (behavioural) ----------------
    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] round_fn(input logic [319:0] s, input logic [7:0] c);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 ^= {56'h0, c};
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        x0 ^= rotr(x0, 19) ^ rotr(x0, 28);
        x1 ^= rotr(x1, 61) ^ rotr(x1, 39);
        x2 ^= rotr(x2, 1) ^ rotr(x2, 6);
        x3 ^= rotr(x3, 10) ^ rotr(x3, 17);
        x4 ^= rotr(x4, 7) ^ rotr(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] perm_fn(input logic [319:0] s, input int nr);
        logic [319:0] r;
        r = s;
        for (int i = 12 - nr; i < 12; i++) r = round_fn(r, 8'(((15 - i) << 4) | i));
        return r;
    endfunction

    // Core model: counts constant-injection phases since the round-1 select and
    // presents that many final rounds of the permutation of perm_in.
    logic [3:0] core_cnt = '0;
    always @(posedge clk) begin
        if (perm_sel1) core_cnt <= 4'd0;
        else if (perm_sel_cst) core_cnt <= core_cnt + 4'd1;
    end
    assign perm_out = perm_fn(perm_in, int'(core_cnt));

    // ---------------- operation description and reference ----------------
    localparam logic [127:0] KatKey = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KatTag = 128'hE355159F292911F794CB1432A0103A8A;

    logic [127:0] op_key, op_nonce, op_tag, ref_tag;
    logic [63:0]  op_ct[8], ref_pt[8];
    logic [3:0]   ref_bytes[8];
    logic [2:0]   op_n;
    int           op_nblk, op_gap[8], low_run[8];
    bit           op_spurious, op_timeout;
    int           done_lat, pt_late, pt_base, done_base;
    logic         busy_at_done;

    task automatic ref_model();
        logic [319:0] s;
        logic [63:0]  x0, c, p;
        int           last, lo;
        s = perm_fn({64'h80400c0600000000, op_key, op_nonce}, 12);
        s[127:0] ^= op_key;
        s[0] ^= 1'b1;
        last = op_nblk - 1;
        for (int i = 0; i < last; i++) begin
            ref_pt[i] = op_ct[i] ^ s[319:256];
            ref_bytes[i] = 4'd8;
            s[319:256] = op_ct[i];
            s = perm_fn(s, 6);
        end
        x0 = s[319:256];
        c = op_ct[last];
        p = '0;
        for (int b = 0; b < 8; b++) begin
            lo = 56 - 8 * b;
            if (b < int'(op_n)) begin
                p[lo +: 8] = c[lo +: 8] ^ x0[lo +: 8];
                x0[lo +: 8] = c[lo +: 8];
            end
            if (b == int'(op_n)) x0[lo +: 8] ^= 8'h80;
        end
        ref_pt[last] = p;
        ref_bytes[last] = {1'b0, op_n};
        s[319:256] = x0;
        s[255:128] ^= op_key;
        s = perm_fn(s, 12);
        ref_tag = s[127:0] ^ op_key;
    endtask

    task automatic rand_op(input int nblk);
        op_key = {$urandom, $urandom, $urandom, $urandom};
        op_nonce = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            op_ct[i] = {$urandom, $urandom};
            op_gap[i] = $urandom_range(0, 3);
        end
        op_nblk = nblk;
        op_n = 3'($urandom);
        op_spurious = 0;
    endtask

    // ---------------- monitor ----------------
    logic [63:0] got_data[$];
    logic [3:0]  got_bytes[$];
    int          done_cnt = 0;
    logic        got_tag_ok = 1'b0;

    always @(negedge clk) begin
        if (pt_valid === 1'b1) begin
            got_data.push_back(pt_data);
            got_bytes.push_back(pt_bytes);
        end
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            got_tag_ok <= tag_ok;
        end
    end

    logic [76:0] all_outs;
    assign all_outs = {busy, ct_ready, pt_valid, pt_data, pt_bytes, done, tag_ok,
                       perm_sel1, perm_sel2, perm_sel_cst, perm_done};

    // ---------------- driver ----------------
    task automatic drive_op();
        int run;
        pt_base = got_data.size();
        done_base = done_cnt;
        op_timeout = 0;
        pt_late = 0;
        @(negedge clk);
        start = 1'b1; key = op_key; nonce = op_nonce; tag_in = op_tag;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < op_nblk; i++) begin
            run = 0;
            while (ct_ready !== 1'b1 && run < 400) begin
                start = op_spurious && (run == 5);
                if (start) begin
                    key = ~op_key; nonce = {$urandom, $urandom, $urandom, $urandom};
                    tag_in = ~op_tag;
                end
                @(negedge clk);
                run++;
            end
            start = 1'b0;
            if (run >= 400) op_timeout = 1;
            low_run[i] = run;
            for (int g = 0; g < op_gap[i]; g++) begin
                ct_valid = 1'b0; ct_last = 1'($urandom); ct_bytes = 3'($urandom);
                ct_data = {$urandom, $urandom};
                @(negedge clk);
            end
            ct_valid = 1'b1;
            ct_data = op_ct[i];
            ct_last = (i == op_nblk - 1);
            ct_bytes = (i == op_nblk - 1) ? op_n : 3'($urandom);
            @(negedge clk);
            if (pt_valid !== 1'b1) pt_late++;
            ct_valid = 1'b0; ct_last = 1'($urandom); ct_bytes = 3'($urandom);
            ct_data = {$urandom, $urandom};
        end
        run = 0;
        while (done !== 1'b1 && run < 400) begin
            start = op_spurious && (run == 5);
            if (start) key = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            run++;
        end
        start = 1'b0;
        busy_at_done = busy;
        done_lat = run;
        if (run >= 400) op_timeout = 1;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (all_outs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        checks++;
        if (perm_in !== '0) begin
            errors++; $display("FAIL reset_perm_in: got %h expected 0", perm_in);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_kat();
        op_key = KatKey; op_nonce = KatKey; op_nblk = 1; op_n = 3'd0;
        op_ct[0] = {$urandom, $urandom}; op_gap[0] = 0; op_spurious = 0;
        op_tag = KatTag;
        drive_op();
        checks++;
        if (op_timeout || done_cnt - done_base != 1) begin
            errors++; $display("FAIL kat_done: got %0d pulses (timeout %0d) expected 1",
                               done_cnt - done_base, op_timeout);
        end
        checks++;
        if (got_tag_ok !== 1'b1) begin
            errors++; $display("FAIL kat_tag_ok: got %b expected 1", got_tag_ok);
        end
        checks++;
        if (got_data.size() != pt_base + 1 || got_bytes[pt_base] !== 4'd0 ||
            got_data[pt_base] !== 64'h0) begin
            errors++; $display("FAIL kat_pt: got %0d outputs, first bytes/data %h/%h expected 1 output 0/0",
                               got_data.size() - pt_base, got_bytes[pt_base], got_data[pt_base]);
        end
        checks++;
        if (low_run[0] != 49 || done_lat != 50) begin
            errors++; $display("FAIL kat_latency: got init %0d final %0d expected 49 50",
                               low_run[0], done_lat);
        end
        checks++;
        if (busy_at_done !== 1'b0) begin
            errors++; $display("FAIL kat_busy_at_done: got %b expected 0", busy_at_done);
        end
        op_tag = KatTag ^ 128'h1;
        drive_op();
        checks++;
        if (op_timeout || done_cnt - done_base != 1 || got_tag_ok !== 1'b0) begin
            errors++; $display("FAIL kat_bad_tag: got pulses %0d tag_ok %b expected 1 and 0",
                               done_cnt - done_base, got_tag_ok);
        end
    endtask

    task automatic test_init_protocol();
        logic [3:0] exp_v, got_v;
        int         run;
        rand_op(1);
        op_n = 3'd0;
        ref_model();
        op_tag = ref_tag;
        done_base = done_cnt;
        @(negedge clk);
        start = 1'b1; key = op_key; nonce = op_nonce; tag_in = op_tag;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (perm_in !== {64'h80400c0600000000, op_key, op_nonce}) begin
            errors++; $display("FAIL init_state: got %h expected IV||key||nonce", perm_in);
        end
        for (int c = 1; c <= 49; c++) begin
            exp_v = {c == 1, (c % 4) == 1, (c % 4) == 2, c == 49};
            got_v = {perm_sel1, perm_sel2, perm_sel_cst, perm_done};
            checks++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL init_strobes cycle %0d: got %b expected %b", c, got_v, exp_v);
            end
            @(negedge clk);
        end
        ct_valid = 1'b1; ct_last = 1'b1; ct_bytes = 3'd0; ct_data = op_ct[0];
        @(negedge clk);
        ct_valid = 1'b0; ct_last = 1'b0;
        run = 0;
        while (done !== 1'b1 && run < 400) begin @(negedge clk); run++; end
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt - done_base != 1 || got_tag_ok !== 1'b1) begin
            errors++; $display("FAIL init_op_result: got pulses %0d tag_ok %b expected 1 and 1",
                               done_cnt - done_base, got_tag_ok);
        end
    endtask

    task automatic test_three_blocks();
        rand_op(3);
        op_n = 3'd3;
        op_gap[0] = 2; op_gap[1] = 1; op_gap[2] = 3;
        ref_model();
        op_tag = ref_tag;
        drive_op();
        checks++;
        if (low_run[1] != 25 || low_run[2] != 25) begin
            errors++; $display("FAIL blocks_ready_low: got %0d %0d expected 25 25",
                               low_run[1], low_run[2]);
        end
        checks++;
        if (got_data.size() != pt_base + 3 || pt_late != 0) begin
            errors++; $display("FAIL blocks_pt_count: got %0d late %0d expected 3 late 0",
                               got_data.size() - pt_base, pt_late);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_data[pt_base + i] !== ref_pt[i] || got_bytes[pt_base + i] !== ref_bytes[i]) begin
                    errors++; $display("FAIL blocks_pt[%0d]: got %h/%0d expected %h/%0d", i,
                                       got_data[pt_base + i], got_bytes[pt_base + i],
                                       ref_pt[i], ref_bytes[i]);
                end
            end
            checks++;
            if (got_data[pt_base + 2][39:0] !== 40'h0) begin
                errors++; $display("FAIL blocks_last_zero: got %h expected low 5 bytes 0",
                                   got_data[pt_base + 2]);
            end
        end
        checks++;
        if (op_timeout || done_cnt - done_base != 1 || got_tag_ok !== 1'b1) begin
            errors++; $display("FAIL blocks_tag: got pulses %0d tag_ok %b expected 1 and 1",
                               done_cnt - done_base, got_tag_ok);
        end
    endtask

    task automatic test_reset_mid();
        int run, pv_base;
        rand_op(1);
        ref_model();
        op_tag = ref_tag;
        @(negedge clk);
        start = 1'b1; key = op_key; nonce = op_nonce; tag_in = op_tag;
        @(negedge clk);
        start = 1'b0;
        run = 0;
        while (ct_ready !== 1'b1 && run < 400) begin @(negedge clk); run++; end
        ct_valid = 1'b1; ct_last = 1'b1; ct_bytes = op_n; ct_data = op_ct[0];
        @(negedge clk);
        ct_valid = 1'b0; ct_last = 1'b0;
        repeat (25) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || perm_sel_cst !== 1'b1) begin
            errors++; $display("FAIL rst_mid_inflight: got busy %b cst %b expected 1 1",
                               busy, perm_sel_cst);
        end
        pv_base = got_data.size();
        done_base = done_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0 || perm_in !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: got %h expected 0", all_outs);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (done_cnt != done_base || got_data.size() != pv_base) begin
            errors++; $display("FAIL rst_mid_no_done: got %0d done %0d pt expected 0 0",
                               done_cnt - done_base, got_data.size() - pv_base);
        end
        drive_op();
        checks++;
        if (op_timeout || done_cnt - done_base != 1 || got_tag_ok !== 1'b1 ||
            got_data.size() != pt_base + 1 || got_data[pt_base] !== ref_pt[0]) begin
            errors++; $display("FAIL rst_mid_rerun: got pulses %0d tag_ok %b pt %h expected 1 1 %h",
                               done_cnt - done_base, got_tag_ok, got_data[pt_base], ref_pt[0]);
        end
    endtask

    task automatic test_start_while_busy();
        rand_op(2);
        op_spurious = 1;
        ref_model();
        op_tag = ref_tag;
        drive_op();
        checks++;
        if (op_timeout || done_cnt - done_base != 1 || got_tag_ok !== 1'b1) begin
            errors++; $display("FAIL busy_start_tag: got pulses %0d tag_ok %b expected 1 1",
                               done_cnt - done_base, got_tag_ok);
        end
        checks++;
        if (got_data.size() != pt_base + 2 || got_data[pt_base + 1] !== ref_pt[1]) begin
            errors++; $display("FAIL busy_start_pt: got %0d outputs last %h expected 2 %h",
                               got_data.size() - pt_base, got_data[pt_base + 1], ref_pt[1]);
        end
    endtask

    task automatic test_random();
        logic exp_ok;
        for (int it = 0; it < 8; it++) begin
            rand_op($urandom_range(1, 5));
            ref_model();
            op_tag = ($urandom_range(0, 1) == 1) ? ref_tag
                                                 : ref_tag ^ (128'h1 << $urandom_range(0, 127));
            exp_ok = (op_tag == ref_tag);
            drive_op();
            checks++;
            if (op_timeout || done_cnt - done_base != 1 || got_tag_ok !== exp_ok) begin
                errors++; $display("FAIL rand%0d_tag: got pulses %0d tag_ok %b expected 1 %b",
                                   it, done_cnt - done_base, got_tag_ok, exp_ok);
            end
            checks++;
            if (got_data.size() != pt_base + op_nblk) begin
                errors++; $display("FAIL rand%0d_pt_count: got %0d expected %0d", it,
                                   got_data.size() - pt_base, op_nblk);
            end else begin
                for (int i = 0; i < op_nblk; i++) begin
                    checks++;
                    if (got_data[pt_base + i] !== ref_pt[i] ||
                        got_bytes[pt_base + i] !== ref_bytes[i]) begin
                        errors++; $display("FAIL rand%0d_pt[%0d]: got %h/%0d expected %h/%0d", it, i,
                                           got_data[pt_base + i], got_bytes[pt_base + i],
                                           ref_pt[i], ref_bytes[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_kat();
        test_init_protocol();
        test_three_blocks();
        test_reset_mid();
        test_start_while_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ascon_dec_ctrl.md
ASCON_DEC_CTRL -- requirements
Module: ascon_dec_ctrl

Interface
REQ-001 SHALL have parameters: IV, default 64'h80400c0600000000, Ascon-128 initial value; RA, default 12, rounds for init/final; RB, default 6, rounds between blocks.
REQ-002 SHALL have ports: clk  in  1  clock (rising edge); rst_n  in  1  async active-low reset.
REQ-003 SHALL have ports: start  in  1  begin decryption; key  in  128  key; nonce  in  128  nonce; tag_in  in  128  expected tag; busy  out  1  operation in progress.
REQ-004 SHALL have ports: ct_valid  in  1; ct_ready  out  1; ct_data  in  64  ciphertext, first byte in [63:56]; ct_last  in  1  final block; ct_bytes  in  3  valid bytes of final block (0-7).
REQ-005 SHALL have ports: pt_valid  out  1; pt_data  out  64  plaintext, invalid bytes zero; pt_bytes  out  4  valid bytes (8 or 0-7).
REQ-006 SHALL have ports: done  out  1  one-cycle completion pulse; tag_ok  out  1  tag match, valid with done.
REQ-007 SHALL have permutation-core ports: perm_sel1, perm_sel2, perm_sel_cst  out  1 each; perm_done  out  1; perm_in  out  320; perm_out  in  320.

Function
REQ-008 SHALL hold state S[319:0] as x0..x4, x0 = S[319:256] the rate lane.
REQ-009 SHALL use FSM states IDLE, INIT, WAIT_CT, PERM_CT, FINAL, CHECK.
REQ-010 SHALL, in IDLE on start, capture key, nonce, tag_in, set S = IV||key||nonce, assert busy, and enter INIT; start outside IDLE SHALL be ignored.
REQ-011 SHALL drive an r-round permutation as 4-cycle rounds: phase P0 perm_sel2=1 (perm_sel1=1 only in round 1, else 0), P1 perm_sel2=0 with perm_sel_cst=1, P2/P3 perm_sel2=0 with perm_sel_cst=0; perm_in = S throughout.
REQ-012 SHALL, in the cycle after P3 of round r (cycle 4r+1 counting the first P0 as 1), assert perm_done for exactly one cycle and load S from perm_out; perm_sel2 SHALL be 1 and perm_sel1 0 in that cycle.
REQ-013 SHALL use a 2-bit phase counter and a 4-bit round counter, both cleared at every permutation start.
REQ-014 SHALL, after INIT's RA rounds, apply S ^= 0^192||key, then S[0] ^= 1 (empty AD domain separation), and enter WAIT_CT.
REQ-015 SHALL assert ct_ready only in WAIT_CT; handshake = ct_valid & ct_ready.
REQ-016 SHALL, on a non-last handshake: pt_data = ct_data ^ x0, pt_bytes = 8, x0 = ct_data, enter PERM_CT (RB rounds), return to WAIT_CT.
REQ-017 SHALL, on a last handshake with n = ct_bytes: pt_data = top n bytes of ct_data ^ x0, rest zero; x0 = top n bytes of ct_data || remaining x0 bytes with 0x80 XORed into byte n; pt_bytes = n; then S ^= 0^64||key||0^128 and enter FINAL (RA rounds).
REQ-018 SHALL register pt_valid/pt_data/pt_bytes, pulsing pt_valid one cycle after the handshake; no back-pressure on pt.
REQ-019 SHALL, in CHECK, compute tag_ok = ((x3||x4) ^ key) == tag_in, pulse done for one cycle with tag_ok held until next start, clear busy, and return to IDLE.
REQ-020 SHALL ignore ct_last/ct_bytes on non-handshake cycles; ct_bytes on non-last blocks is don't-care.

Reset
REQ-021 SHALL, on rst_n low at any time including mid-permutation, asynchronously enter IDLE and zero S, counters, busy, ct_ready, pt_valid, pt_data, pt_bytes, done, tag_ok and all perm_* outputs.
REQ-022 SHALL not emit done or pt_valid for an operation interrupted by reset.

Structure
REQ-023 SHALL place IV, RA, RB, state encoding and lane index constants in shared package ascon_pkg.
REQ-024 SHALL contain one sub-module, ascon_pad_mask, computing the byte mask and 0x80 pad from n.
REQ-025 SHALL not instantiate the permutation core; the integration top connects perm_* ports.

Verification
REQ-026 key=nonce=000102..0F, single last block n=0 -> pt_bytes=0, tag_in=E355159F292911F794CB1432A0103A8A gives tag_ok=1.
REQ-027 same as REQ-026 with tag_in bit 0 flipped -> done pulse, tag_ok=0.
REQ-028 INIT phase -> perm_sel1=1 only in cycle 1, perm_sel_cst pulses every 4 cycles, perm_done at cycle 49.
REQ-029 three blocks (8,8,last n=3) with ct_valid gaps -> ct_ready low during each 25-cycle PERM_CT, pt_valid thrice, last pt_data low 5 bytes zero.
REQ-030 rst_n low during FINAL round 7 -> all outputs 0 immediately, no done; new start then completes normally.
REQ-031 start asserted while busy -> ignored, captured key unchanged, result matches the single-run reference model.
